// File: rtl/jtmx5k_rom_pkg.sv
// Shared types for the ROM slot: fetch FSM states and
// the default client/SDRAM address widths.
package jtmx5k_rom_pkg;

  localparam int ROM_AW       = 17;
  localparam int ROM_SDRAM_AW = 22;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DATA
  } state_e;

endpackage

// File: rtl/jtmx5k_rom_slot_if.sv
// Client ROM bus (client is master) and SDRAM bank
// port (slot is master) used by jtmx5k_rom_slot.
interface jtmx5k_rom_if
  import jtmx5k_rom_pkg::*;
#(
  parameter int AW = ROM_AW
);
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_ok;

  modport master (
    output rom_cs, rom_addr,
    input  rom_data, rom_ok
  );

  modport slave (
    input  rom_cs, rom_addr,
    output rom_data, rom_ok
  );
endinterface

interface jtmx5k_sdram_if
  import jtmx5k_rom_pkg::*;
#(
  parameter int SDRAM_AW = ROM_SDRAM_AW
);
  logic                sdram_req;
  logic [SDRAM_AW-1:0] sdram_addr;
  logic                sdram_ack;
  logic                sdram_rdy;
  logic [15:0]         sdram_din;

  modport master (
    output sdram_req, sdram_addr,
    input  sdram_ack, sdram_rdy, sdram_din
  );

  modport slave (
    input  sdram_req, sdram_addr,
    output sdram_ack, sdram_rdy, sdram_din
  );
endinterface

// File: rtl/jtmx5k_rom_slot.sv
// Byte-wide ROM client slot with a one-word cache in
// front of a 16-bit SDRAM bank port.
module jtmx5k_rom_slot
  import jtmx5k_rom_pkg::*;
#(
  parameter int                  AW       = ROM_AW,
  parameter int                  SDRAM_AW = ROM_SDRAM_AW,
  parameter logic [SDRAM_AW-1:0] OFFSET   = '0
) (
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  jtmx5k_rom_if.slave    rom,
  jtmx5k_sdram_if.master sdram
);

  state_e              state_q;
  logic                valid_q;
  logic                discard_q;
  logic [AW-2:0]       tag_q;
  logic [AW-2:0]       fetch_tag_q;
  logic [15:0]         word_q;
  logic                req_q;
  logic [SDRAM_AW-1:0] addr_q;

  logic [AW-2:0]       tag_d;
  logic [SDRAM_AW-1:0] addr_d;
  logic                hit;
  logic                store;

  assign tag_d  = rom.rom_addr[AW-1:1];
  assign addr_d = OFFSET + SDRAM_AW'(tag_d);
  assign hit    = valid_q & (tag_q == tag_d);

  // ack and rdy together in WAIT_ACK count as ack-then-rdy
  assign store = sdram.sdram_rdy &
                 ((state_q == WAIT_DATA) |
                  ((state_q == WAIT_ACK) & sdram.sdram_ack));

  assign rom.rom_ok   = rom.rom_cs & hit;
  assign rom.rom_data = rom.rom_addr[0] ? word_q[15:8]
                                        : word_q[7:0];

  assign sdram.sdram_req  = req_q;
  assign sdram.sdram_addr = addr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      discard_q   <= 1'b0;
      tag_q       <= '0;
      fetch_tag_q <= '0;
      word_q      <= '0;
      req_q       <= 1'b0;
      addr_q      <= '0;
    end else begin
      if (flush) valid_q <= 1'b0;
      if (store) begin
        word_q  <= sdram.sdram_din;
        tag_q   <= fetch_tag_q;
        valid_q <= ~(discard_q | flush);
      end
      unique case (state_q)
        IDLE: begin
          discard_q <= 1'b0;
          if (rom.rom_cs & ~hit & ~flush) begin
            fetch_tag_q <= tag_d;
            addr_q      <= addr_d;
            req_q       <= 1'b1;
            state_q     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (flush) discard_q <= 1'b1;
          if (sdram.sdram_ack) begin
            req_q   <= 1'b0;
            state_q <= store ? IDLE : WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (flush) discard_q <= 1'b1;
          if (store) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (store) discard_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtmx5k_rom_slot.sv
// Directed bench for jtmx5k_rom_slot: cache hit/miss,
// mid-fetch moves, flush discard, offset wrap, reset.
module tb_jtmx5k_rom_slot;

  logic clk;
  logic rstn;
  logic flush0;
  logic flush1;

  int n_chk;
  int n_err;

  jtmx5k_rom_if   #(.AW(17))       r0 ();
  jtmx5k_sdram_if #(.SDRAM_AW(22)) s0 ();
  jtmx5k_rom_if   #(.AW(17))       r1 ();
  jtmx5k_sdram_if #(.SDRAM_AW(22)) s1 ();

  jtmx5k_rom_slot #(
    .AW(17), .SDRAM_AW(22), .OFFSET(22'h0)
  ) u_dut0 (
    .clk(clk), .rstn(rstn), .flush(flush0),
    .rom(r0.slave), .sdram(s0.master)
  );

  jtmx5k_rom_slot #(
    .AW(17), .SDRAM_AW(22), .OFFSET(22'h3FFFFF)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .flush(flush1),
    .rom(r1.slave), .sdram(s1.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack0();
    s0.sdram_ack = 1'b1;
    tick();
    s0.sdram_ack = 1'b0;
  endtask

  task automatic rdy0(input logic [15:0] d);
    s0.sdram_rdy = 1'b1;
    s0.sdram_din = d;
    tick();
    s0.sdram_rdy = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rstn = 1'b0;
    flush0 = 1'b0;
    flush1 = 1'b0;
    r0.rom_cs = 1'b1;
    r0.rom_addr = 17'h00123;
    r1.rom_cs = 1'b0;
    r1.rom_addr = 17'h00002;
    s0.sdram_ack = 1'b0;
    s0.sdram_rdy = 1'b0;
    s0.sdram_din = 16'h0;
    s1.sdram_ack = 1'b0;
    s1.sdram_rdy = 1'b0;
    s1.sdram_din = 16'h0;

    #3;
    chk("rst_ok", 32'(r0.rom_ok), 32'd0);
    chk("rst_data", 32'(r0.rom_data), 32'h00);
    chk("rst_req", 32'(s0.sdram_req), 32'd0);
    chk("rst_addr", 32'(s0.sdram_addr), 32'h0);
    #19 rstn = 1'b1;

    // cold miss on 0x123
    tick();
    chk("cold_req", 32'(s0.sdram_req), 32'd1);
    chk("cold_addr", 32'(s0.sdram_addr), 32'h00091);
    chk("cold_ok0", 32'(r0.rom_ok), 32'd0);
    tick();
    tick();
    ack0();
    chk("cold_req_drop", 32'(s0.sdram_req), 32'd0);
    tick();
    tick();
    tick();
    rdy0(16'hBEEF);
    chk("cold_ok", 32'(r0.rom_ok), 32'd1);
    chk("cold_data", 32'(r0.rom_data), 32'hBE);

    // same-word hit
    r0.rom_addr = 17'h00122;
    #1;
    chk("hit_ok", 32'(r0.rom_ok), 32'd1);
    chk("hit_data", 32'(r0.rom_data), 32'hEF);
    tick();
    chk("hit_noreq", 32'(s0.sdram_req), 32'd0);
    chk("hit_ok2", 32'(r0.rom_ok), 32'd1);

    // address moves mid-fetch
    r0.rom_addr = 17'h00200;
    #1;
    chk("mv_ok0", 32'(r0.rom_ok), 32'd0);
    tick();
    chk("mv_addr1", 32'(s0.sdram_addr), 32'h00100);
    ack0();
    r0.rom_addr = 17'h00400;
    rdy0(16'h1234);
    chk("mv_ok_stale", 32'(r0.rom_ok), 32'd0);
    tick();
    chk("mv_req2", 32'(s0.sdram_req), 32'd1);
    chk("mv_addr2", 32'(s0.sdram_addr), 32'h00200);
    ack0();
    rdy0(16'h5678);
    chk("mv_ok", 32'(r0.rom_ok), 32'd1);
    chk("mv_data", 32'(r0.rom_data), 32'h78);
    r0.rom_addr = 17'h00201;
    #1;
    chk("mv_old_miss", 32'(r0.rom_ok), 32'd0);

    // flush in WAIT_DATA discards the returning word
    r0.rom_addr = 17'h00300;
    tick();
    chk("fl_addr", 32'(s0.sdram_addr), 32'h00180);
    ack0();
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    rdy0(16'hAAAA);
    chk("fl_ok0", 32'(r0.rom_ok), 32'd0);
    tick();
    chk("fl_rereq", 32'(s0.sdram_req), 32'd1);
    chk("fl_readdr", 32'(s0.sdram_addr), 32'h00180);
    ack0();
    rdy0(16'hCAFE);
    chk("fl_ok", 32'(r0.rom_ok), 32'd1);
    chk("fl_data", 32'(r0.rom_data), 32'hFE);

    // offset wrap on the second slot
    r1.rom_cs = 1'b1;
    tick();
    chk("wrap_req", 32'(s1.sdram_req), 32'd1);
    chk("wrap_addr", 32'(s1.sdram_addr), 32'h000000);
    s1.sdram_ack = 1'b1;
    s1.sdram_rdy = 1'b1;
    s1.sdram_din = 16'h55AA;
    tick();
    s1.sdram_ack = 1'b0;
    s1.sdram_rdy = 1'b0;
    chk("wrap_ackrdy_ok", 32'(r1.rom_ok), 32'd1);
    chk("wrap_data", 32'(r1.rom_data), 32'hAA);
    r1.rom_addr = 17'h00004;
    tick();
    chk("wrap_addr2", 32'(s1.sdram_addr), 32'h000001);

    // reset pulsed while waiting for ack
    r0.rom_addr = 17'h00500;
    tick();
    chk("rs_req", 32'(s0.sdram_req), 32'd1);
    r0.rom_addr = 17'h00301;
    #1;
    chk("rs_ok_pre", 32'(r0.rom_ok), 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("rs_req0", 32'(s0.sdram_req), 32'd0);
    chk("rs_ok0", 32'(r0.rom_ok), 32'd0);
    #1 rstn = 1'b1;
    tick();
    chk("rs_fresh_req", 32'(s0.sdram_req), 32'd1);
    chk("rs_fresh_addr", 32'(s0.sdram_addr), 32'h00180);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
